// File: rtl/block_render_pkg.sv
// Shared widths, result struct and selector state encoding for the block
// renderer depth-selection path.
package block_render_pkg;

  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int TIME_W = 18;
  localparam int BX_W   = 12;
  localparam int BY_W   = 12;
  localparam int BZ_W   = 14;
  localparam int T_W    = 32;
  localparam int IDX_W  = 5;
  localparam int ID_W   = 8;
  localparam int DIR_W  = 3;

  // Screen-space footprint of a block and of the saber tip, in pixels.
  localparam int BLOCK_SIZE = 64;
  localparam int SABER_SIZE = 16;

  localparam logic [IDX_W-1:0] NO_HIT_INDEX = 5'd31;
  localparam logic [T_W-1:0]   NO_HIT_T     = 32'hFFFF_FFFF;

  typedef struct packed {
    logic             hit;
    logic [T_W-1:0]   t;
    logic [IDX_W-1:0] index;
  } isect_result_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sel_state_t;

  // True when p lies in the half-open span [lo, lo + size).
  function automatic logic in_span(input logic [12:0] p, input logic [12:0] lo,
                                   input logic [12:0] size);
    return (p >= lo) && (p < (lo + size));
  endfunction

endpackage

// File: rtl/ray_box_intersector.sv
// Orthographic ray/box test: the pixel ray runs along +Z, so a candidate is
// hit when the pixel falls inside its square footprint and t is its depth.
// Pipelined with II=1; the candidate index travels with the result.
module ray_box_intersector
  import block_render_pkg::*;
#(
  parameter int INT_LAT = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             cand_valid,
  input  logic [IDX_W-1:0] cand_index,
  input  logic             cand_is_saber,
  input  logic [X_W-1:0]   px,
  input  logic [Y_W-1:0]   py,
  input  logic [BX_W-1:0]  box_x,
  input  logic [BY_W-1:0]  box_y,
  input  logic [BZ_W-1:0]  box_z,
  output logic             res_valid,
  output isect_result_t    res
);

  isect_result_t    stage0;
  logic [12:0]      span;
  logic [INT_LAT-1:0] vld_pipe;
  isect_result_t    data_pipe [INT_LAT];

  // Evaluate the footprint test for the candidate presented this cycle.
  always_comb begin
    span         = cand_is_saber ? 13'(SABER_SIZE) : 13'(BLOCK_SIZE);
    stage0.hit   = in_span({2'b00, px}, {1'b0, box_x}, span) &&
                   in_span({3'b000, py}, {1'b0, box_y}, span);
    stage0.t     = {{(T_W-BZ_W){1'b0}}, box_z};
    stage0.index = cand_index;
  end

  // Delay line giving a fixed INT_LAT-cycle latency; reset discards in-flight work.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_pipe <= '0;
      for (int i = 0; i < INT_LAT; i++) data_pipe[i] <= '0;
    end else begin
      vld_pipe[0]  <= cand_valid;
      data_pipe[0] <= stage0;
      for (int i = 1; i < INT_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign res_valid = vld_pipe[INT_LAT-1];
  assign res       = data_pipe[INT_LAT-1];

endmodule

// File: rtl/multi_block_depth_selector.sv
// Per-pixel nearest-block selector: scans every candidate block through the
// ray/box intersector and reports the nearest visible, not-yet-sliced hit.
// Optional feature macro: SABER_EN adds the saber tip as an extra candidate
// (index NUM_BLOCKS) whose hit overrides any block hit.
module multi_block_depth_selector
  import block_render_pkg::*;
#(
  parameter int NUM_BLOCKS = 12,
  parameter int NUM_SLICED = 12,
  parameter int INT_LAT    = 4
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [X_W-1:0]                      x_in,
  input  logic [Y_W-1:0]                      y_in,
  input  logic [TIME_W-1:0]                   curr_time_in,
  input  logic                                valid_in,
  output logic                                ready_out,
  input  logic [NUM_BLOCKS-1:0][BX_W-1:0]     block_x_in,
  input  logic [NUM_BLOCKS-1:0][BY_W-1:0]     block_y_in,
  input  logic [NUM_BLOCKS-1:0][BZ_W-1:0]     block_z_in,
  input  logic [NUM_BLOCKS-1:0]               block_color_in,
  input  logic [NUM_BLOCKS-1:0][DIR_W-1:0]    block_direction_in,
  input  logic [NUM_BLOCKS-1:0][ID_W-1:0]     block_ID_in,
  input  logic [NUM_BLOCKS-1:0]               block_visible_in,
  input  logic [NUM_SLICED-1:0][ID_W-1:0]     sliced_blocks,
  input  logic [BX_W-1:0]                     hand_x_in,
  input  logic [BY_W-1:0]                     hand_y_in,
  input  logic [BZ_W-1:0]                     hand_z_in,
  output logic [X_W-1:0]                      x_out,
  output logic [Y_W-1:0]                      y_out,
  output logic [TIME_W-1:0]                   curr_time_out,
  output logic [BX_W-1:0]                     block_x_out,
  output logic [BY_W-1:0]                     block_y_out,
  output logic [BZ_W-1:0]                     block_z_out,
  output logic                                block_color_out,
  output logic [DIR_W-1:0]                    block_direction_out,
  output logic [ID_W-1:0]                     block_ID_out,
  output logic [IDX_W-1:0]                    block_index_out,
  output logic [T_W-1:0]                      t_out,
  output logic                                block_visible_out,
  output logic                                saber_visible_out,
  output logic                                valid_out,
  input  logic                                ready_in
);

`ifdef SABER_EN
  localparam int NC = NUM_BLOCKS + 1;
`else
  localparam int NC = NUM_BLOCKS;
  logic unused_hand;
  assign unused_hand = ^{hand_x_in, hand_y_in, hand_z_in};
`endif
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NC - 1);
  localparam logic [IDX_W-1:0] SABER_IDX = IDX_W'(NUM_BLOCKS);

  sel_state_t       state, next_state;
  logic             accept, cand_valid, cand_is_saber, last_res;
  logic [IDX_W-1:0] cnt;
  logic [X_W-1:0]   px_r;
  logic [Y_W-1:0]   py_r;
  logic [TIME_W-1:0] time_r;
  logic [BX_W-1:0]  cand_x;
  logic [BY_W-1:0]  cand_y;
  logic [BZ_W-1:0]  cand_z;
  logic             res_valid;
  isect_result_t    res;

  logic             res_vis, res_sliced, res_is_saber, qual_block, qual_saber;
  logic [ID_W-1:0]  res_id;
  logic             best_hit, nxt_best_hit, saber_hit, nxt_saber_hit;
  logic [T_W-1:0]   best_t, nxt_best_t, saber_t, nxt_saber_t;
  logic [IDX_W-1:0] best_idx, nxt_best_idx;

  logic [BX_W-1:0]  win_x;
  logic [BY_W-1:0]  win_y;
  logic [BZ_W-1:0]  win_z;
  logic             win_color;
  logic [DIR_W-1:0] win_dir;
  logic [ID_W-1:0]  win_id;

  // Reset forces ready low asynchronously; otherwise ready only while idle.
  assign ready_out = (state == IDLE) && !rst_in;
  assign accept    = valid_in && ready_out;
  assign last_res  = res_valid && (res.index == LAST_IDX);

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic and candidate issue strobe.
  always_comb begin
    next_state = state;
    cand_valid = 1'b0;
    case (state)
      IDLE:  begin
        if (accept) next_state = ISSUE;
        else        next_state = IDLE;
      end
      ISSUE: begin
        cand_valid = 1'b1;
        if (cnt == LAST_IDX) next_state = DRAIN;
        else                 next_state = ISSUE;
      end
      DRAIN: begin
        if (last_res) next_state = DONE;
        else          next_state = DRAIN;
      end
      DONE:  begin
        if (ready_in) next_state = IDLE;
        else          next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Candidate counter: one candidate issued per ISSUE cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)               cnt <= '0;
    else if (accept)          cnt <= '0;
    else if (state == ISSUE)  cnt <= cnt + 5'd1;
    else                      cnt <= cnt;
  end

  // Capture the accepted pixel.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      px_r   <= '0;
      py_r   <= '0;
      time_r <= '0;
    end else if (accept) begin
      px_r   <= x_in;
      py_r   <= y_in;
      time_r <= curr_time_in;
    end else begin
      px_r   <= px_r;
      py_r   <= py_r;
      time_r <= time_r;
    end
  end

  // Route the current candidate's geometry to the intersector.
  always_comb begin
    cand_x        = '0;
    cand_y        = '0;
    cand_z        = '0;
    cand_is_saber = 1'b0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (cnt == IDX_W'(i)) begin
        cand_x = block_x_in[i];
        cand_y = block_y_in[i];
        cand_z = block_z_in[i];
      end
    end
`ifdef SABER_EN
    if (cnt == SABER_IDX) begin
      cand_x        = hand_x_in;
      cand_y        = hand_y_in;
      cand_z        = hand_z_in;
      cand_is_saber = 1'b1;
    end
`endif
  end

  ray_box_intersector #(.INT_LAT(INT_LAT)) u_isect (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .cand_valid    (cand_valid),
    .cand_index    (cnt),
    .cand_is_saber (cand_is_saber),
    .px            (px_r),
    .py            (py_r),
    .box_x         (cand_x),
    .box_y         (cand_y),
    .box_z         (cand_z),
    .res_valid     (res_valid),
    .res           (res)
  );

  // Qualify the returning result and fold it into the running best.
  always_comb begin
    res_vis = 1'b0;
    res_id  = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (res.index == IDX_W'(i)) begin
        res_vis = block_visible_in[i];
        res_id  = block_ID_in[i];
      end
    end
    res_sliced = 1'b0;
    for (int j = 0; j < NUM_SLICED; j++) begin
      if (sliced_blocks[j] == res_id) res_sliced = 1'b1;
    end
`ifdef SABER_EN
    res_is_saber = (res.index == SABER_IDX);
`else
    res_is_saber = 1'b0;
`endif
    qual_block = res_valid && res.hit && !res_is_saber && res_vis && !res_sliced;
    qual_saber = res_valid && res.hit && res_is_saber;

    // Strict less-than keeps the earlier (lower-index) candidate on a tie.
    if (qual_block && (!best_hit || (res.t < best_t))) begin
      nxt_best_hit = 1'b1;
      nxt_best_t   = res.t;
      nxt_best_idx = res.index;
    end else begin
      nxt_best_hit = best_hit;
      nxt_best_t   = best_t;
      nxt_best_idx = best_idx;
    end

    if (qual_saber) begin
      nxt_saber_hit = 1'b1;
      nxt_saber_t   = res.t;
    end else begin
      nxt_saber_hit = saber_hit;
      nxt_saber_t   = saber_t;
    end
  end

  // Running best registers, cleared for every new pixel.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in || accept) begin
      best_hit  <= 1'b0;
      best_t    <= NO_HIT_T;
      best_idx  <= NO_HIT_INDEX;
      saber_hit <= 1'b0;
      saber_t   <= NO_HIT_T;
    end else begin
      best_hit  <= nxt_best_hit;
      best_t    <= nxt_best_t;
      best_idx  <= nxt_best_idx;
      saber_hit <= nxt_saber_hit;
      saber_t   <= nxt_saber_t;
    end
  end

  // Look up the attributes of the winning block.
  always_comb begin
    win_x     = '0;
    win_y     = '0;
    win_z     = '0;
    win_color = 1'b0;
    win_dir   = '0;
    win_id    = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (nxt_best_idx == IDX_W'(i)) begin
        win_x     = block_x_in[i];
        win_y     = block_y_in[i];
        win_z     = block_z_in[i];
        win_color = block_color_in[i];
        win_dir   = block_direction_in[i];
        win_id    = block_ID_in[i];
      end
    end
  end

  // Output registers: loaded on the last result, held until the handshake.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_out           <= 1'b0;
      x_out               <= '0;
      y_out               <= '0;
      curr_time_out       <= '0;
      block_x_out         <= '0;
      block_y_out         <= '0;
      block_z_out         <= '0;
      block_color_out     <= 1'b0;
      block_direction_out <= '0;
      block_ID_out        <= '0;
      block_index_out     <= '0;
      t_out               <= '0;
      block_visible_out   <= 1'b0;
      saber_visible_out   <= 1'b0;
    end else if ((state == DRAIN) && last_res) begin
      valid_out     <= 1'b1;
      x_out         <= px_r;
      y_out         <= py_r;
      curr_time_out <= time_r;
      if (nxt_saber_hit) begin
        saber_visible_out   <= 1'b1;
        block_visible_out   <= 1'b0;
        t_out               <= nxt_saber_t;
        block_index_out     <= SABER_IDX;
        block_x_out         <= '0;
        block_y_out         <= '0;
        block_z_out         <= '0;
        block_color_out     <= 1'b0;
        block_direction_out <= '0;
        block_ID_out        <= '0;
      end else if (nxt_best_hit) begin
        saber_visible_out   <= 1'b0;
        block_visible_out   <= 1'b1;
        t_out               <= nxt_best_t;
        block_index_out     <= nxt_best_idx;
        block_x_out         <= win_x;
        block_y_out         <= win_y;
        block_z_out         <= win_z;
        block_color_out     <= win_color;
        block_direction_out <= win_dir;
        block_ID_out        <= win_id;
      end else begin
        saber_visible_out   <= 1'b0;
        block_visible_out   <= 1'b0;
        t_out               <= NO_HIT_T;
        block_index_out     <= NO_HIT_INDEX;
        block_x_out         <= '0;
        block_y_out         <= '0;
        block_z_out         <= '0;
        block_color_out     <= 1'b0;
        block_direction_out <= '0;
        block_ID_out        <= '0;
      end
    end else if ((state == DONE) && ready_in) begin
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_out;
    end
  end

endmodule

// File: tb/tb_multi_block_depth_selector.sv
// Directed + randomized bench for multi_block_depth_selector with a
// behavioural nearest-hit reference model. Honours SABER_EN if defined.
module tb_multi_block_depth_selector;

  localparam int NB  = 12;
  localparam int NS  = 12;
  localparam int LAT = 4;
`ifdef SABER_EN
  localparam int NC = NB + 1;
`else
  localparam int NC = NB;
`endif

  logic clk_in, rst_in;
  logic [10:0] x_in;  logic [9:0] y_in;  logic [17:0] curr_time_in;
  logic valid_in, ready_out, ready_in;
  logic [NB-1:0][11:0] block_x_in, block_y_in;
  logic [NB-1:0][13:0] block_z_in;
  logic [NB-1:0]       block_color_in, block_visible_in;
  logic [NB-1:0][2:0]  block_direction_in;
  logic [NB-1:0][7:0]  block_ID_in;
  logic [NS-1:0][7:0]  sliced_blocks;
  logic [11:0] hand_x_in, hand_y_in;  logic [13:0] hand_z_in;
  logic [10:0] x_out;  logic [9:0] y_out;  logic [17:0] curr_time_out;
  logic [11:0] block_x_out, block_y_out;  logic [13:0] block_z_out;
  logic block_color_out;  logic [2:0] block_direction_out;  logic [7:0] block_ID_out;
  logic [4:0] block_index_out;  logic [31:0] t_out;
  logic block_visible_out, saber_visible_out, valid_out;

  int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;
  int e_px, e_py, e_tm, e_idx, e_bvis, e_svis, e_bx, e_by, e_bz, e_col, e_dir, e_id;
  logic [31:0] e_t;

  multi_block_depth_selector #(.NUM_BLOCKS(NB), .NUM_SLICED(NS), .INT_LAT(LAT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .curr_time_in(curr_time_in), .valid_in(valid_in), .ready_out(ready_out),
    .block_x_in(block_x_in), .block_y_in(block_y_in), .block_z_in(block_z_in),
    .block_color_in(block_color_in), .block_direction_in(block_direction_in),
    .block_ID_in(block_ID_in), .block_visible_in(block_visible_in),
    .sliced_blocks(sliced_blocks), .hand_x_in(hand_x_in), .hand_y_in(hand_y_in),
    .hand_z_in(hand_z_in), .x_out(x_out), .y_out(y_out), .curr_time_out(curr_time_out),
    .block_x_out(block_x_out), .block_y_out(block_y_out), .block_z_out(block_z_out),
    .block_color_out(block_color_out), .block_direction_out(block_direction_out),
    .block_ID_out(block_ID_out), .block_index_out(block_index_out), .t_out(t_out),
    .block_visible_out(block_visible_out), .saber_visible_out(saber_visible_out),
    .valid_out(valid_out), .ready_in(ready_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: pixel ray along +Z hits a 64x64 block footprint (16x16 for the
  // saber); nearest qualified block wins, lowest index on ties; saber overrides.
  task automatic model(input int px, input int py, input int tm);
    int best, bt;
    bit hit, sl;
    e_px = px; e_py = py; e_tm = tm;
    best = -1; bt = 0;
    for (int i = 0; i < NB; i++) begin
      hit = (px >= int'(block_x_in[i])) && (px < int'(block_x_in[i]) + 64) &&
            (py >= int'(block_y_in[i])) && (py < int'(block_y_in[i]) + 64);
      sl = 0;
      for (int j = 0; j < NS; j++) if (sliced_blocks[j] == block_ID_in[i]) sl = 1;
      if (hit && block_visible_in[i] && !sl && (best < 0 || int'(block_z_in[i]) < bt)) begin
        best = i;
        bt   = int'(block_z_in[i]);
      end
    end
    e_bvis = 0; e_svis = 0; e_t = 32'hFFFF_FFFF; e_idx = 31;
    e_bx = 0; e_by = 0; e_bz = 0; e_col = 0; e_dir = 0; e_id = 0;
`ifdef SABER_EN
    if ((px >= int'(hand_x_in)) && (px < int'(hand_x_in) + 16) &&
        (py >= int'(hand_y_in)) && (py < int'(hand_y_in) + 16)) begin
      e_svis = 1; e_t = 32'(hand_z_in); e_idx = NB;
      return;
    end
`endif
    if (best >= 0) begin
      e_bvis = 1; e_t = 32'(bt); e_idx = best;
      e_bx = int'(block_x_in[best]); e_by = int'(block_y_in[best]);
      e_bz = int'(block_z_in[best]); e_col = int'(block_color_in[best]);
      e_dir = int'(block_direction_in[best]); e_id = int'(block_ID_in[best]);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid"}, valid_out, 1);
    check({tag, "_x"}, x_out, e_px);
    check({tag, "_y"}, y_out, e_py);
    check({tag, "_time"}, curr_time_out, e_tm);
    check({tag, "_idx"}, block_index_out, e_idx);
    check({tag, "_t"}, t_out, e_t);
    check({tag, "_bvis"}, block_visible_out, e_bvis);
    check({tag, "_svis"}, saber_visible_out, e_svis);
    check({tag, "_bx"}, block_x_out, e_bx);
    check({tag, "_by"}, block_y_out, e_by);
    check({tag, "_bz"}, block_z_out, e_bz);
    check({tag, "_col"}, block_color_out, e_col);
    check({tag, "_dir"}, block_direction_out, e_dir);
    check({tag, "_id"}, block_ID_out, e_id);
  endtask

  task automatic set_default();
    for (int i = 0; i < NB; i++) begin
      block_x_in[i] = 12'd4000; block_y_in[i] = 12'd4000;
      block_z_in[i] = 14'(1000 + i); block_color_in[i] = i[0];
      block_direction_in[i] = 3'(i); block_ID_in[i] = 8'(i + 1);
      block_visible_in[i] = 1'b1;
    end
    for (int j = 0; j < NS; j++) sliced_blocks[j] = 8'hEE;
    hand_x_in = 12'd4000; hand_y_in = 12'd4000; hand_z_in = 14'd900;
  endtask

  task automatic put(input int i, input int bx, input int by, input int bz);
    block_x_in[i] = 12'(bx); block_y_in[i] = 12'(by); block_z_in[i] = 14'(bz);
  endtask

  // One pixel transaction; ready_in held low for 'hold' cycles after valid_out.
  task automatic run_pixel(input string tag, input int px, input int py, input int tm,
                           input int hold, input bit poke_valid);
    int n, cyc;
    n = 0;
    while (ready_out !== 1'b1 && n < 50) begin tick(); n++; end
    check({tag, "_ready"}, ready_out, 1);
    x_in = 11'(px); y_in = 10'(py); curr_time_in = 18'(tm);
    model(px, py, tm);
    valid_in = 1'b1; ready_in = (hold == 0);
    tick();
    valid_in = 1'b0;
    cyc = 1;
    while (valid_out !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    check({tag, "_latency"}, cyc, NC + LAT + 1);
    check_all(tag);
    for (int h = 0; h < hold; h++) begin
      if (poke_valid) begin x_in = 11'd7; valid_in = 1'b1; end
      tick();
      check_all({tag, "_hold"});
      check({tag, "_hold_ready"}, ready_out, 0);
    end
    valid_in = 1'b0; ready_in = 1'b1;
    tick();
    check({tag, "_drop"}, valid_out, 0);
    check({tag, "_rearm"}, ready_out, 1);
  endtask

  initial begin
    int seen;
    rst_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    x_in = '0; y_in = '0; curr_time_in = '0;
    set_default();
    #2 rst_in = 1'b1;
    tick(); tick();
    check("rst_valid", valid_out, 0);
    check("rst_ready", ready_out, 0);
    check("rst_t", t_out, 0);
    check("rst_idx", block_index_out, 0);
    rst_in = 1'b0;
    #1;
    check("rst_release_ready", ready_out, 1);

    // Nearest of two hits.
    put(3, 80, 80, 500); put(7, 80, 80, 200);
    run_pixel("nearest", 100, 100, 18'h1234, 0, 0);

    // Tie on t: lower index wins.
    set_default(); put(2, 60, 70, 300); put(5, 90, 90, 300);
    run_pixel("tie", 100, 100, 77, 0, 0);

    // Nearest block already sliced.
    set_default(); put(3, 80, 80, 500); put(7, 80, 80, 200);
    block_ID_in[7] = 8'h2A; sliced_blocks[4] = 8'h2A;
    run_pixel("sliced", 100, 100, 5, 0, 0);

    // Saber over a very close block.
    set_default(); put(0, 80, 80, 10);
    hand_x_in = 12'd90; hand_y_in = 12'd90; hand_z_in = 14'd900;
    run_pixel("saber", 100, 100, 9, 0, 0);

    // Only hit is invisible: no-hit result.
    set_default(); put(4, 80, 80, 20); block_visible_in[4] = 1'b0;
    run_pixel("nohit", 100, 100, 3, 0, 0);

    // Footprint edges: last covered pixel and first uncovered pixel.
    set_default(); put(4, 100, 100, 50);
    run_pixel("edge_in", 163, 163, 1, 0, 0);
    run_pixel("edge_out", 164, 100, 2, 0, 0);

    // Backpressure with a stray valid_in during the hold.
    set_default(); put(6, 10, 10, 33);
    run_pixel("bp", 20, 20, 11, 5, 1);
    seen = 0;
    for (int c = 0; c < NC + LAT + 5; c++) begin
      tick();
      if (valid_out === 1'b1) seen = 1;
    end
    check("bp_no_ghost", seen, 0);

    // Reset mid-scan discards the pixel.
    set_default(); put(1, 80, 80, 40);
    valid_in = 1'b1; x_in = 11'd100; y_in = 10'd100;
    tick();
    valid_in = 1'b0;
    tick(); tick(); tick();
    rst_in = 1'b1;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_ready", ready_out, 0);
    check("mid_rst_x", x_out, 0);
    check("mid_rst_t", t_out, 0);
    tick();
    rst_in = 1'b0;
    #1;
    check("mid_rst_release_ready", ready_out, 1);
    seen = 0;
    for (int c = 0; c < NC + LAT + 8; c++) begin
      tick();
      if (valid_out === 1'b1) seen = 1;
    end
    check("mid_rst_no_output", seen, 0);
    run_pixel("post_rst", 100, 100, 44, 0, 0);

    // Randomized scenes with overlaps, ties, invisibility and slicing.
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < NB; i++) begin
        put(i, $urandom_range(0, 200), $urandom_range(0, 200), $urandom_range(0, 7));
        block_visible_in[i] = ($urandom_range(0, 3) != 0);
        block_color_in[i] = 1'($urandom_range(0, 1));
        block_direction_in[i] = 3'($urandom_range(0, 7));
        block_ID_in[i] = 8'(i + 1);
      end
      for (int j = 0; j < NS; j++) sliced_blocks[j] = 8'($urandom_range(1, 30));
      hand_x_in = 12'($urandom_range(0, 250)); hand_y_in = 12'($urandom_range(0, 250));
      hand_z_in = 14'($urandom_range(0, 16383));
      run_pixel($sformatf("rand%0d", r), $urandom_range(0, 250), $urandom_range(0, 250),
                $urandom_range(0, 262143), $urandom_range(0, 3), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/multi_block_depth_selector.md
MULTI_BLOCK_DEPTH_SELECTOR -- requirements
Module: multi_block_depth_selector

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 12, number of candidate blocks (2..30).
REQ-002 SHALL have parameter NUM_SLICED, default 12, depth of the sliced-ID list.
REQ-003 SHALL have parameter INT_LAT, default 4, fixed latency in cycles of the intersector sub-module (>=1).
REQ-004 SHALL have ports clk_in input 1, sole clock; rst_in input 1, reset, asynchronous and active-high.
REQ-005 SHALL have ports x_in input 11, pixel X; y_in input 10, pixel Y; curr_time_in input 18, frame time; valid_in input 1; ready_out output 1.
REQ-006 SHALL have ports block_x_in input NUM_BLOCKS x 12; block_y_in input NUM_BLOCKS x 12; block_z_in input NUM_BLOCKS x 14; block_color_in input NUM_BLOCKS x 1; block_direction_in input NUM_BLOCKS x 3; block_ID_in input NUM_BLOCKS x 8; block_visible_in input NUM_BLOCKS x 1.
REQ-007 SHALL have ports sliced_blocks input NUM_SLICED x 8, IDs already cut; hand_x_in input 12; hand_y_in input 12; hand_z_in input 14, saber tip position.
REQ-008 SHALL have ports x_out output 11; y_out output 10; curr_time_out output 18; block_x_out output 12; block_y_out output 12; block_z_out output 14; block_color_out output 1; block_direction_out output 3; block_ID_out output 8; block_index_out output 5; t_out output 32; block_visible_out output 1; saber_visible_out output 1; valid_out output 1; ready_in input 1.

Function
REQ-009 SHALL use FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE, with one pixel in flight; ready_out=1 only in IDLE.
REQ-010 SHALL accept a pixel on valid_in&&ready_out (cycle 0), capture x_in, y_in and curr_time_in, and enter ISSUE.
REQ-011 SHALL issue candidate k (0..NC-1) to the intersector at cycle 1+k, where NC=NUM_BLOCKS, plus 1 saber candidate when SABER_EN is defined; the saber candidate has index NUM_BLOCKS and is treated as always visible.
REQ-012 SHALL, on each intersector result, qualify a block hit as hit && visible && ID not in sliced_blocks, comparing the ID of that candidate.
REQ-013 SHALL select the qualified block hit with the smallest unsigned t; on equal t, the lower index wins.
REQ-014 SHALL give priority to any saber hit over all block hits.
REQ-015 SHALL register outputs in DONE; valid_out rises at cycle NC+INT_LAT+1 after accept.
REQ-016 SHALL hold valid_out and all outputs stable until valid_out&&ready_in, then return to IDLE; ready_out may reassert in the following cycle.
REQ-017 SHALL drive, with no qualified hit: block_visible_out=0, saber_visible_out=0, t_out=32'hFFFFFFFF, block_index_out=31; with a saber hit: saber_visible_out=1, block_visible_out=0.
REQ-018 SHALL require upstream to hold the block, hand and sliced inputs stable from accept until output handshake; behaviour when they change in that window is undefined.
REQ-019 SHALL ignore valid_in while not in IDLE.

Reset
REQ-020 SHALL, on rst_in asserted at any time including mid-scan, immediately go to IDLE, discard the in-flight pixel and intersector results, and force valid_out=0, ready_out=0 while asserted, and all data outputs to 0.
REQ-021 SHALL assert ready_out in the first cycle after rst_in deasserts.

Configuration
REQ-022 SHALL, with SABER_EN defined, evaluate the saber candidate (NC=NUM_BLOCKS+1); without it, NC=NUM_BLOCKS, the hand_* ports are unused, and saber_visible_out is tied to 0.

Structure
REQ-023 SHALL take the coordinate widths, the t width, and the result struct (hit, t, index) from a shared package, block_render_pkg.
REQ-024 SHALL instantiate exactly one sub-module, ray_box_intersector, which is pipelined with II=1 and latency INT_LAT, and passes the candidate index through.

Verification
REQ-025 SHALL test: blocks 3 and 7 hit with t=500 and t=200 -> index 7, t_out=200, valid_out at cycle NC+INT_LAT+1.
REQ-026 SHALL test: blocks 2 and 5 both hit with t=300 -> index 2.
REQ-027 SHALL test: block 7 (ID 0x2A) nearest and 0x2A in sliced_blocks, block 3 t=500 -> index 3.
REQ-028 SHALL test: saber hits and block 0 hits with t=10 (SABER_EN) -> saber_visible_out=1, block_visible_out=0; without SABER_EN -> index 0.
REQ-029 SHALL test: ready_in held 0 for 5 cycles -> outputs stable, ready_out=0, a new valid_in ignored.
REQ-030 SHALL test: rst_in pulsed at scan cycle 4 -> valid_out never asserts for that pixel, and ready_out=1 in the cycle after release.
